conv_loop_ctrl: RTL and testbench

- Sequences one convolution layer pass over the conv datapath.
- Walks output-row, output-col, kernel-row and kernel-col counters in nested order, issuing one tap index set per cycle to the MAC/address logic.
- Flags first and last tap of each output window so the accumulator can be cleared and written back.
- After the final tap, waits for MAC pipeline drain, then pulses done for one cycle.

---
 rtl/conv_loop_ctrl.sv | 70 +++++++
 tb/tb_conv_loop_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: sequences one conv layer pass (row, col, kr, kc taps), then drains the MAC pipe and pulses done
// start_i begins a pass from IDLE; stall_i freezes tap issue while running.
// busy_o covers RUN and DRAIN; done_o is a one-cycle pulse after the drain.
// valid_o qualifies row_o/col_o/kr_o/kc_o; first_o/last_o mark window edges.
module conv_loop_ctrl #(
  parameter int OUT_ROW = 4,
  parameter int OUT_COL = 4,
  parameter int KERNEL = 3,
  parameter int DRAIN_CYC = 2,
  localparam int RW = $clog2(OUT_ROW) < 1 ? 1 : $clog2(OUT_ROW),
  localparam int CW = $clog2(OUT_COL) < 1 ? 1 : $clog2(OUT_COL),
  localparam int KW = $clog2(KERNEL) < 1 ? 1 : $clog2(KERNEL),
  localparam int DW = $clog2(DRAIN_CYC + 1) < 1 ? 1 : $clog2(DRAIN_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          stall_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          valid_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [KW-1:0] kr_o,
  output logic [KW-1:0] kc_o,
  output logic          first_o,
  output logic          last_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC > 0 ? DRAIN_CYC - 1 : 0);
  state_t state;
  logic [DW-1:0] dcnt;
  logic kc_end, kr_end, col_end, row_end;
  assign kc_end = kc_o == KW'(KERNEL - 1);
  assign kr_end = kr_o == KW'(KERNEL - 1);
  assign col_end = col_o == CW'(OUT_COL - 1);
  assign row_end = row_o == RW'(OUT_ROW - 1);
  assign valid_o = state == RUN && !stall_i;
  assign busy_o = state == RUN || state == DRAIN;
  assign done_o = state == DONE;
  assign first_o = valid_o && kr_o == '0 && kc_o == '0;
  assign last_o = valid_o && kr_end && kc_end;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt <= '0;
      row_o <= '0;
      col_o <= '0;
      kr_o <= '0;
      kc_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN: if (!stall_i) begin
          kc_o <= kc_end ? '0 : kc_o + 1'b1;
          if (kc_end) kr_o <= kr_end ? '0 : kr_o + 1'b1;
          if (kc_end && kr_end) col_o <= col_end ? '0 : col_o + 1'b1;
          if (kc_end && kr_end && col_end) row_o <= row_end ? '0 : row_o + 1'b1;
          if (kc_end && kr_end && col_end && row_end) begin
            state <= DRAIN_CYC == 0 ? DONE : DRAIN;
            dcnt <= '0;
          end
        end
        DRAIN: if (dcnt == DLAST) state <= DONE; else dcnt <= dcnt + 1'b1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: checks two conv_loop_ctrl configurations against a tap-count model plus literal pins
module tb_conv_loop_ctrl;
  logic clk = 0, rst = 1;
  logic start_a = 0, stall_a = 0, start_b = 0, stall_b = 0;
  logic busy_a, done_a, valid_a, first_a, last_a;
  logic [1:0] row_a, col_a, kr_a, kc_a;
  logic busy_b, done_b, valid_b, first_b, last_b;
  logic row_b, col_b, kr_b, kc_b;
  int checks = 0, fails = 0, cyc = 0;
  int nt[2] = '{144, 4}, kk[2] = '{3, 1}, oc[2] = '{4, 2}, dr[2] = '{2, 0};
  int act[2], tap[2], post[2], sedge[2];
  int ntap[2], nfirst[2], nlast[2], ndone[2], done_rel[2], last_busy[2], first_valid[2], last_valid[2];
  int tapv[2][144];

  conv_loop_ctrl dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .stall_i(stall_a), .busy_o(busy_a), .done_o(done_a),
    .valid_o(valid_a), .row_o(row_a), .col_o(col_a), .kr_o(kr_a), .kc_o(kc_a), .first_o(first_a), .last_o(last_a)
  );
  conv_loop_ctrl #(.OUT_ROW(2), .OUT_COL(2), .KERNEL(1), .DRAIN_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .stall_i(stall_b), .busy_o(busy_b), .done_o(done_b),
    .valid_o(valid_b), .row_o(row_b), .col_o(col_b), .kr_o(kr_b), .kc_o(kc_b), .first_o(first_b), .last_o(last_b)
  );

  always #5 clk = ~clk;

  task automatic check(int d, string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL dut%0d %s: got %0d expected %0d", d, n, a, e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0;
        tap[i] = 0;
        post[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          if (i == 1 ? start_b : start_a) begin
            act[i] = 1; tap[i] = 0; post[i] = 0; sedge[i] = cyc;
            ntap[i] = 0; nfirst[i] = 0; nlast[i] = 0; ndone[i] = 0;
            done_rel[i] = 0; last_busy[i] = 0; first_valid[i] = 0; last_valid[i] = 0;
          end
        end else if (tap[i] < nt[i]) begin
          if (!(i == 1 ? stall_b : stall_a)) tap[i]++;
        end else if (post[i] == dr[i]) act[i] = 0;
        else post[i]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int t, k2, er, ec, ekr, ekc, rel;
      bit run, v, sl;
      logic [31:0] ab, ad, av, ar, ac, akr, akc, af, al;
      sl = i == 1 ? stall_b : stall_a;
      run = act[i] != 0 && tap[i] < nt[i];
      v = run && !sl;
      t = run ? tap[i] : 0;
      k2 = kk[i] * kk[i];
      er = t / (oc[i] * k2);
      ec = (t / k2) % oc[i];
      ekr = (t / kk[i]) % kk[i];
      ekc = t % kk[i];
      if (i == 0) begin
        ab = busy_a; ad = done_a; av = valid_a; ar = row_a; ac = col_a; akr = kr_a; akc = kc_a; af = first_a; al = last_a;
      end else begin
        ab = busy_b; ad = done_b; av = valid_b; ar = row_b; ac = col_b; akr = kr_b; akc = kc_b; af = first_b; al = last_b;
      end
      check(i, "busy", ab, run || (act[i] != 0 && tap[i] == nt[i] && post[i] < dr[i]));
      check(i, "done", ad, act[i] != 0 && tap[i] == nt[i] && post[i] == dr[i]);
      check(i, "valid", av, v);
      check(i, "row", ar, er);
      check(i, "col", ac, ec);
      check(i, "kr", akr, ekr);
      check(i, "kc", akc, ekc);
      check(i, "first", af, v && ekr == 0 && ekc == 0);
      check(i, "last", al, v && ekr == kk[i] - 1 && ekc == kk[i] - 1);
      rel = cyc - sedge[i] + 1;
      if (av == 1) begin
        if (ntap[i] < 144) tapv[i][ntap[i]] = ar * 1000 + ac * 100 + akr * 10 + akc + af * 10000 + al * 20000;
        ntap[i]++;
        nfirst[i] += af;
        nlast[i] += al;
        if (ntap[i] == 1) first_valid[i] = rel;
        last_valid[i] = rel;
      end
      if (ab == 1) last_busy[i] = rel;
      if (ad == 1) begin
        ndone[i]++;
        done_rel[i] = rel;
      end
    end
  end

  task automatic pulse_start(bit a, bit b);
    start_a = a; start_b = b;
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
  endtask

  task automatic wait_done(int d, int lim);
    int n = 0;
    while (ndone[d] == 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(d, "done_seen", ndone[d] != 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check(0, "rst_busy", busy_a, 0);
    check(0, "rst_done", done_a, 0);
    check(1, "rst_valid", valid_b, 0);
    rst = 0;
    @(posedge clk); #1;
    pulse_start(1, 1);
    wait_done(1, 20);
    wait_done(0, 400);
    repeat (3) @(posedge clk); #1;
    check(1, "taps", ntap[1], 4);
    check(1, "firsts", nfirst[1], 4);
    check(1, "lasts", nlast[1], 4);
    check(1, "done_cycle", done_rel[1], 5);
    check(1, "tap2", tapv[1][2], 31000);
    check(1, "tap3", tapv[1][3], 31100);
    check(0, "taps", ntap[0], 144);
    check(0, "firsts", nfirst[0], 16);
    check(0, "lasts", nlast[0], 16);
    check(0, "first_valid", first_valid[0], 1);
    check(0, "last_valid", last_valid[0], 144);
    check(0, "last_busy", last_busy[0], 146);
    check(0, "done_cycle", done_rel[0], 147);
    check(0, "done_count", ndone[0], 1);
    check(0, "tap0", tapv[0][0], 10000);
    check(0, "tap8", tapv[0][8], 20022);
    check(0, "tap9", tapv[0][9], 10100);
    check(0, "tap143", tapv[0][143], 23322);
    pulse_start(1, 0);
    repeat (9) @(posedge clk);
    #1 stall_a = 1;
    @(negedge clk);
    check(0, "stall_valid", valid_a, 0);
    check(0, "stall_idx", {row_a, col_a, kr_a, kc_a}, 8'b00_01_00_00);
    repeat (5) @(posedge clk);
    #1 stall_a = 0;
    repeat (35) @(posedge clk);
    #1;
    pulse_start(1, 0);
    wait_done(0, 400);
    repeat (10) @(posedge clk); #1;
    check(0, "stall_done_cycle", done_rel[0], 152);
    check(0, "stall_taps", ntap[0], 144);
    check(0, "restart_done_count", ndone[0], 1);
    pulse_start(1, 0);
    repeat (59) @(posedge clk);
    #1 rst = 1;
    #1;
    check(0, "abort_busy", busy_a, 0);
    check(0, "abort_valid", valid_a, 0);
    check(0, "abort_row", row_a, 0);
    check(0, "abort_col", col_a, 0);
    @(posedge clk); #1 rst = 0;
    repeat (200) @(posedge clk); #1;
    check(0, "abort_no_done", ndone[0], 0);
    check(0, "abort_idle", busy_a, 0);
    pulse_start(1, 0);
    wait_done(0, 400);
    repeat (3) @(posedge clk); #1;
    check(0, "post_abort_taps", ntap[0], 144);
    check(0, "post_abort_tap0", tapv[0][0], 10000);
    check(0, "post_abort_done_cycle", done_rel[0], 147);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
